decoder_scan_driver: RTL and testbench

//  Upstream sequencer for the 3-to-8 enable decoder: generates the 3-bit select I and the

---
 rtl/decoder_scan_driver.sv | 105 ++++++++++
 tb/tb_decoder_scan_driver.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_driver.sv
// Select/enable sequencer for a 3-to-8 enable decoder: scans I through 0..LAST with blanked slot starts.
// Optional per-index enable mask via `define SCAN_MASK_EN (adds the MASK port).
module decoder_scan_driver #(
  parameter int unsigned DIV   = 100000,
  parameter int unsigned BLANK = 4,
  parameter int unsigned LAST  = 7
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RUN,
`ifdef SCAN_MASK_EN
  input  logic [7:0] MASK,
`endif
  output logic [2:0] I,
  output logic       EN,
  output logic       SLOT_STB,
  output logic       FRAME_STB
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_END   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [2:0]    I_LAST    = 3'(LAST);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_ON    = 2'd2
  } state_t;

  // A slot opens blanked unless blanking is disabled entirely.
  localparam state_t S_START = (BLANK == 0) ? S_ON : S_BLANK;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      i_n;
  logic            en_n;
  logic            slot_n;
  logic            frame_n;
  logic            mask_bit;

`ifdef SCAN_MASK_EN
  assign mask_bit = MASK[i_n];
`else
  assign mask_bit = 1'b1;
`endif

  // Next-state, next-index and strobe logic.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    i_n     = I;
    slot_n  = 1'b0;
    frame_n = 1'b0;
    case (state)
      S_IDLE: begin
        if (RUN) begin
          state_n = S_START;
          cnt_n   = '0;
          i_n     = 3'd0;
          slot_n  = 1'b1;
          frame_n = 1'b1;
        end
      end
      default: begin
        if (!RUN) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else if (cnt == CNT_END) begin
          state_n = S_START;
          cnt_n   = '0;
          i_n     = (I == I_LAST) ? 3'd0 : I + 3'd1;
          slot_n  = 1'b1;
          frame_n = (i_n == 3'd0);
        end else begin
          cnt_n = cnt + CW'(1);
          if ((state == S_BLANK) && (cnt == BLANK_END)) begin
            state_n = S_ON;
          end
        end
      end
    endcase
    // EN follows the next state so it switches on the same edge as I.
    en_n = (state_n == S_ON) && mask_bit;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      cnt       <= '0;
      I         <= 3'd0;
      EN        <= 1'b0;
      SLOT_STB  <= 1'b0;
      FRAME_STB <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      I         <= i_n;
      EN        <= en_n;
      SLOT_STB  <= slot_n;
      FRAME_STB <= frame_n;
    end
  end

endmodule

// File: tb/tb_decoder_scan_driver.sv
// Bench for decoder_scan_driver: directed vector table plus a phase-based reference model,
// covering DIV=5/BLANK=2/LAST=2 and a second instance with DIV=5/BLANK=0/LAST=0.
module tb_decoder_scan_driver;

  localparam int unsigned TB_DIV = 5;

  typedef struct packed {
    logic [2:0] i;
    logic       en;
    logic       slot;
    logic       frame;
  } out_t;

  typedef struct packed {
    logic rst;
    logic run;
    out_t exp;
  } vec_t;

  logic       CLK;
  logic       RST;
  logic       RUN;
  logic [7:0] mask;
  logic [2:0] i1, i2;
  logic       en1, en2, slot1, slot2, frame1, frame2;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  out_t q1[$];
  out_t q2[$];
  vec_t tv[$];

  bit       act1 = 0, act2 = 0;
  int       p1 = 0, p2 = 0;
  logic [2:0] li1 = 3'd0, li2 = 3'd0;

  decoder_scan_driver #(.DIV(TB_DIV), .BLANK(2), .LAST(2)) dut1 (
    .CLK(CLK), .RST(RST), .RUN(RUN),
`ifdef SCAN_MASK_EN
    .MASK(mask),
`endif
    .I(i1), .EN(en1), .SLOT_STB(slot1), .FRAME_STB(frame1)
  );

  decoder_scan_driver #(.DIV(TB_DIV), .BLANK(0), .LAST(0)) dut2 (
    .CLK(CLK), .RST(RST), .RUN(RUN),
`ifdef SCAN_MASK_EN
    .MASK(mask),
`endif
    .I(i2), .EN(en2), .SLOT_STB(slot2), .FRAME_STB(frame2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: position within an active scan is a single phase count since the last start.
  function automatic void model(input bit rst, input bit run, input int blank, input int last,
                                input logic [7:0] mk, inout bit act, inout int p,
                                inout logic [2:0] li, output out_t o);
    int c, s, idx;
    o = '0;
    if (rst) begin
      act = 0;
      li  = 3'd0;
    end else if (!run) begin
      act = 0;
      o.i = li;
    end else begin
      if (!act) begin
        act = 1;
        p   = 0;
      end else begin
        p = p + 1;
      end
      c       = p % TB_DIV;
      s       = p / TB_DIV;
      idx     = s % (last + 1);
      o.i     = 3'(idx);
      o.en    = (c >= blank) && mk[idx];
      o.slot  = (c == 0);
      o.frame = (c == 0) && (idx == 0);
      li      = o.i;
    end
  endfunction

  function automatic vec_t mkv(input logic r, input logic rn, input int i,
                               input logic e, input logic s, input logic f);
    vec_t v;
    v.rst       = r;
    v.run       = rn;
    v.exp.i     = 3'(i);
    v.exp.en    = e;
    v.exp.slot  = s;
    v.exp.frame = f;
    return v;
  endfunction

  task automatic check(input string name, input out_t got, input out_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got I=%0d EN=%b SLOT=%b FRAME=%b, expected I=%0d EN=%b SLOT=%b FRAME=%b",
               name, cycle, got.i, got.en, got.slot, got.frame, exp.i, exp.en, exp.slot, exp.frame);
    end
  endtask

  // Drive one clock of inputs, queue expectations, then compare after the edge.
  task automatic step(input logic r, input logic rn, input bit use_tab, input out_t tab);
    out_t m1, m2, e, g;
    RST = r;
    RUN = rn;
    model(r, rn, 2, 2, mask, act1, p1, li1, m1);
    model(r, rn, 0, 0, mask, act2, p2, li2, m2);
    q1.push_back(use_tab ? tab : m1);
    q2.push_back(m2);
    @(posedge CLK);
    #1;
    cycle++;
    e = q1.pop_front();
    g.i = i1; g.en = en1; g.slot = slot1; g.frame = frame1;
    check(use_tab ? "table" : "scan_b2_l2", g, e);
    e = q2.pop_front();
    g.i = i2; g.en = en2; g.slot = slot2; g.frame = frame2;
    check("scan_b0_l0", g, e);
  endtask

  initial begin
    out_t none;
    none = '0;
`ifdef SCAN_MASK_EN
    mask = 8'b0000_0101;
`else
    mask = 8'hFF;
`endif
    RST = 1'b1;
    RUN = 1'b1;

    // reset held with RUN high
    repeat (3) tv.push_back(mkv(1, 1, 0, 0, 0, 0));
    // start: slot I=0 then I=1
    tv.push_back(mkv(0, 1, 0, 0, 1, 1));
    tv.push_back(mkv(0, 1, 0, 0, 0, 0));
    tv.push_back(mkv(0, 1, 0, 1, 0, 0));
    tv.push_back(mkv(0, 1, 0, 1, 0, 0));
    tv.push_back(mkv(0, 1, 0, 1, 0, 0));
    tv.push_back(mkv(0, 1, 1, 0, 1, 0));
    tv.push_back(mkv(0, 1, 1, 0, 0, 0));
    tv.push_back(mkv(0, 1, 1, 1, 0, 0));
    // RUN drops in ON of slot 1, then restarts at I=0
    tv.push_back(mkv(0, 0, 1, 0, 0, 0));
    tv.push_back(mkv(0, 0, 1, 0, 0, 0));
    tv.push_back(mkv(0, 1, 0, 0, 1, 1));
    tv.push_back(mkv(0, 1, 0, 0, 0, 0));
    tv.push_back(mkv(0, 1, 0, 1, 0, 0));
    tv.push_back(mkv(0, 1, 0, 1, 0, 0));
    // one-clock reset mid-ON, then restart
    tv.push_back(mkv(1, 1, 0, 0, 0, 0));
    tv.push_back(mkv(0, 1, 0, 0, 1, 1));
    tv.push_back(mkv(0, 1, 0, 0, 0, 0));

    foreach (tv[k]) begin
      vec_t v;
      v = tv[k];
      v.exp.en = v.exp.en & mask[v.exp.i];
      step(v.rst, v.run, 1'b1, v.exp);
    end

    // steady scan across several frames
    for (int n = 0; n < 45; n++) step(1'b0, 1'b1, 1'b0, none);

    // mostly-running traffic with occasional stops and resets
    for (int n = 0; n < 160; n++) begin
      logic r, rn;
      r  = ($urandom_range(0, 39) == 0);
      rn = ($urandom_range(0, 7) != 0);
      step(r, rn, 1'b0, none);
    end

    // clean finish: stop and confirm hold
    step(1'b0, 1'b0, 1'b0, none);
    step(1'b0, 1'b0, 1'b0, none);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
